// File: rtl/hazard_interlock_ctrl_pkg.sv
// Shared definitions for the 5-stage pipeline interlock controller.
// Holds the NOP encoding, the stage enumeration, the default return-address
// register and the tracker entry layout used for in-flight destinations.
package hazard_interlock_ctrl_pkg;

  // Default return-address register, read by ret and written by call.
  localparam int RA_REG_DEF = 31;

  // Tracker rd field width; covers any REG_AW up to this value.
  localparam int RD_MAX_W = 8;

  // Encoding the datapath loads into the OF/EX latch for a bubble.
  localparam logic [31:0] NOP_INSN = 32'h6800_0000;

  typedef enum logic [2:0] {STG_IF, STG_OF, STG_EX, STG_MA, STG_RW} stage_e;

  // Tracker covers EX, MA and RW.
  localparam int TRK_DEPTH = 3;

  typedef struct packed {
    logic                vld;
    logic                wb;
    logic [RD_MAX_W-1:0] rd;
    logic                isld;
  } trk_entry_t;

  // Tracker slot for a pipeline stage (EX is slot 0).
  function automatic int trk_slot(stage_e s);
    return int'(s) - int'(STG_EX);
  endfunction

endpackage

// File: rtl/hazard_interlock_ctrl_sat_counter.sv
// Saturating event counter.
// Ports:
//   clk  rising-edge clock
//   rst  synchronous active-high clear
//   inc  count one event this cycle
//   cnt  events since reset, holds at all-ones
module sat_counter #(
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             inc,
  output logic [CNT_W-1:0] cnt
);

  always_ff @(posedge clk) begin
    if (rst)
      cnt <= '0;
    else if (inc && (cnt != '1))
      cnt <= cnt + CNT_W'(1);
  end

endmodule

// File: rtl/hazard_interlock_ctrl.sv
// Pipeline interlock controller for the IF/OF/EX/MA/RW core.
// Tracks destinations in flight in EX/MA/RW and stalls the OF instruction
// while any of its register-file sources would be read stale. A taken
// branch squashes the OF slot and wins over a hazard. No data forwarding.
// Ports:
//   clk, rst          clock, synchronous active-high reset
//   of_valid          OF holds a real instruction
//   of_rs1/of_rs2     source registers, of_use1/of_use2 qualify them
//   of_rd/of_wb       destination and write-back enable of OF instruction
//   of_isld           OF instruction is a load
//   br_taken          EX resolved a taken branch this cycle
//   stall             hold PC and IF/OF latch
//   ex_bubble         load NOP into OF/EX latch at next edge
//   of_squash         kill OF instruction (branch shadow)
//   wb_expect/rd_exp  RW entry writes back / its destination
//   stall_cnt         stalled cycles since reset (saturating)
//   flush_cnt         taken-branch cycles since reset (saturating)
module hazard_interlock_ctrl
  import hazard_interlock_ctrl_pkg::*;
#(
  parameter int REG_AW = 5,
  parameter int RA_REG = RA_REG_DEF,
  parameter bit FWD_EN = 1'b0,
  parameter int CNT_W  = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              of_valid,
  input  logic [REG_AW-1:0] of_rs1,
  input  logic [REG_AW-1:0] of_rs2,
  input  logic              of_use1,
  input  logic              of_use2,
  input  logic [REG_AW-1:0] of_rd,
  input  logic              of_wb,
  input  logic              of_isld,
  input  logic              br_taken,
  output logic              stall,
  output logic              ex_bubble,
  output logic              of_squash,
  output logic              wb_expect,
  output logic [REG_AW-1:0] wb_rd_exp,
  output logic [CNT_W-1:0]  stall_cnt,
  output logic [CNT_W-1:0]  flush_cnt
);

  localparam int SL_EX = trk_slot(STG_EX);
  localparam int SL_RW = trk_slot(STG_RW);

  // RA_REG only has to be addressable; callers pre-mux it onto rs1/rd.
  if ((REG_AW > RD_MAX_W) || (RA_REG >= (1 << REG_AW))) begin : g_cfg_err
    $error("hazard_interlock_ctrl: REG_AW/RA_REG out of range");
  end

  trk_entry_t [TRK_DEPTH-1:0] trk;
  trk_entry_t                 issue_ent;
  logic [TRK_DEPTH-1:0]       hit1, hit2;
  logic                       m1, m2, hazard, issue;

  // Per-slot destination compare. RW still counts: the register file
  // writes on the same edge OF reads, so there is no write-through.
  for (genvar k = 0; k < TRK_DEPTH; k++) begin : g_cmp
    assign hit1[k] = trk[k].vld & trk[k].wb & (trk[k].rd == RD_MAX_W'(of_rs1));
    assign hit2[k] = trk[k].vld & trk[k].wb & (trk[k].rd == RD_MAX_W'(of_rs2));
  end

  if (FWD_EN) begin : g_fwd
    // Forwarding covers everything except a load still in EX.
    assign m1 = hit1[SL_EX] & trk[SL_EX].isld;
    assign m2 = hit2[SL_EX] & trk[SL_EX].isld;
  end else begin : g_nofwd
    assign m1 = |hit1;
    assign m2 = |hit2;
  end

  always_comb begin
    hazard    = of_valid & ((of_use1 & m1) | (of_use2 & m2));
    issue     = of_valid & ~hazard & ~br_taken;
    stall     = hazard & ~br_taken;
    ex_bubble = hazard | br_taken | ~of_valid;
    of_squash = br_taken;

    issue_ent = '0;
    if (issue) begin
      issue_ent.vld  = 1'b1;
      issue_ent.wb   = of_wb;
      issue_ent.rd   = RD_MAX_W'(of_rd);
      issue_ent.isld = of_isld;
    end
  end

  // EX..RW always advance; a stalled or squashed OF slot enters as a bubble.
  always_ff @(posedge clk) begin
    if (rst)
      trk <= '0;
    else
      trk <= {trk[TRK_DEPTH-2:0], issue_ent};
  end

  assign wb_expect = trk[SL_RW].vld & trk[SL_RW].wb;
  assign wb_rd_exp = trk[SL_RW].rd[REG_AW-1:0];

  // The load flag of the oldest entry has no consumer.
  logic unused_ok;
  assign unused_ok = &{1'b0, trk[SL_RW].isld};

  sat_counter #(.CNT_W(CNT_W)) u_stall_cnt (
    .clk (clk),
    .rst (rst),
    .inc (stall),
    .cnt (stall_cnt)
  );

  sat_counter #(.CNT_W(CNT_W)) u_flush_cnt (
    .clk (clk),
    .rst (rst),
    .inc (br_taken),
    .cnt (flush_cnt)
  );

endmodule

// File: tb/tb_hazard_interlock_ctrl.sv
module tb_hazard_interlock_ctrl;

  typedef struct {
    logic       v;
    logic [4:0] rs1;
    logic       u1;
    logic [4:0] rs2;
    logic       u2;
    logic [4:0] rd;
    logic       wb;
    logic       ld;
  } in_t;

  typedef struct {
    int         dut;
    int         tag;
    logic       stall;
    logic       bub;
    logic       sq;
    logic       wbe;
    logic [4:0] wbrd;
    bit         cchk;
    int         scnt;
    int         fcnt;
  } exp_t;

  logic       clk;
  logic       rst, of_valid, of_use1, of_use2, of_wb, of_isld, br_taken;
  logic [4:0] of_rs1, of_rs2, of_rd;

  // index 0: FWD_EN=0, 1: FWD_EN=1, 2: FWD_EN=0 with 4-bit counters
  logic [2:0]  o_stall, o_bub, o_sq, o_wbe;
  logic [4:0]  o_wbrd [3];
  logic [31:0] o_scnt [3];
  logic [31:0] o_fcnt [3];
  logic [31:0] a_scnt, a_fcnt, b_scnt, b_fcnt;
  logic [3:0]  c_scnt, c_fcnt;

  int   checks = 0;
  int   errors = 0;
  int   tag = 0;
  exp_t sbq[$];

  hazard_interlock_ctrl #(.REG_AW(5), .RA_REG(31), .FWD_EN(1'b0), .CNT_W(32)) u_a (
    .clk(clk), .rst(rst), .of_valid(of_valid), .of_rs1(of_rs1), .of_rs2(of_rs2),
    .of_use1(of_use1), .of_use2(of_use2), .of_rd(of_rd), .of_wb(of_wb), .of_isld(of_isld),
    .br_taken(br_taken), .stall(o_stall[0]), .ex_bubble(o_bub[0]), .of_squash(o_sq[0]),
    .wb_expect(o_wbe[0]), .wb_rd_exp(o_wbrd[0]), .stall_cnt(a_scnt), .flush_cnt(a_fcnt));

  hazard_interlock_ctrl #(.REG_AW(5), .RA_REG(31), .FWD_EN(1'b1), .CNT_W(32)) u_b (
    .clk(clk), .rst(rst), .of_valid(of_valid), .of_rs1(of_rs1), .of_rs2(of_rs2),
    .of_use1(of_use1), .of_use2(of_use2), .of_rd(of_rd), .of_wb(of_wb), .of_isld(of_isld),
    .br_taken(br_taken), .stall(o_stall[1]), .ex_bubble(o_bub[1]), .of_squash(o_sq[1]),
    .wb_expect(o_wbe[1]), .wb_rd_exp(o_wbrd[1]), .stall_cnt(b_scnt), .flush_cnt(b_fcnt));

  hazard_interlock_ctrl #(.REG_AW(5), .RA_REG(31), .FWD_EN(1'b0), .CNT_W(4)) u_c (
    .clk(clk), .rst(rst), .of_valid(of_valid), .of_rs1(of_rs1), .of_rs2(of_rs2),
    .of_use1(of_use1), .of_use2(of_use2), .of_rd(of_rd), .of_wb(of_wb), .of_isld(of_isld),
    .br_taken(br_taken), .stall(o_stall[2]), .ex_bubble(o_bub[2]), .of_squash(o_sq[2]),
    .wb_expect(o_wbe[2]), .wb_rd_exp(o_wbrd[2]), .stall_cnt(c_scnt), .flush_cnt(c_fcnt));

  assign o_scnt[0] = a_scnt;
  assign o_fcnt[0] = a_fcnt;
  assign o_scnt[1] = b_scnt;
  assign o_fcnt[1] = b_fcnt;
  assign o_scnt[2] = {28'd0, c_scnt};
  assign o_fcnt[2] = {28'd0, c_fcnt};

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic in_t raw(logic v, logic [4:0] rs1, logic u1, logic [4:0] rs2, logic u2,
                              logic [4:0] rd, logic wb, logic ld);
    in_t i;
    i.v = v; i.rs1 = rs1; i.u1 = u1; i.rs2 = rs2; i.u2 = u2;
    i.rd = rd; i.wb = wb; i.ld = ld;
    return i;
  endfunction

  function automatic in_t alu(logic [4:0] rd, logic [4:0] a, logic [4:0] b);
    return raw(1'b1, a, 1'b1, b, 1'b1, rd, 1'b1, 1'b0);
  endfunction
  function automatic in_t ldi(logic [4:0] rd, logic [4:0] a);
    return raw(1'b1, a, 1'b1, 5'd0, 1'b0, rd, 1'b1, 1'b1);
  endfunction
  function automatic in_t nop_i();
    return raw(1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0);
  endfunction
  function automatic in_t call_i();
    return raw(1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 5'd31, 1'b1, 1'b0);
  endfunction
  function automatic in_t ret_i();
    return raw(1'b1, 5'd31, 1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0);
  endfunction

  function automatic exp_t E(int d, logic s, logic b, logic q, logic w, logic [4:0] rd);
    exp_t e;
    e.dut = d; e.tag = 0; e.stall = s; e.bub = b; e.sq = q; e.wbe = w; e.wbrd = rd;
    e.cchk = 1'b0; e.scnt = 0; e.fcnt = 0;
    return e;
  endfunction
  function automatic exp_t EC(int d, logic s, logic b, logic q, logic w, logic [4:0] rd,
                              int sc, int fc);
    exp_t e;
    e = E(d, s, b, q, w, rd);
    e.cchk = 1'b1; e.scnt = sc; e.fcnt = fc;
    return e;
  endfunction

  task automatic drive(input in_t i, input logic r, input logic b);
    @(posedge clk);
    #1;
    rst = r; of_valid = i.v; of_rs1 = i.rs1; of_use1 = i.u1; of_rs2 = i.rs2;
    of_use2 = i.u2; of_rd = i.rd; of_wb = i.wb; of_isld = i.ld; br_taken = b;
  endtask

  task automatic cyc(input in_t i, input logic r, input logic b, input exp_t e);
    drive(i, r, b);
    e.tag = tag;
    tag++;
    sbq.push_back(e);
  endtask

  task automatic rst_cycle();
    drive(nop_i(), 1'b1, 1'b0);
  endtask

  task automatic chk(input int t, input int d, input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s dut%0d vec%0d: got %0d expected %0d", nm, d, t, act, exp);
    end
  endtask

  // Monitor: one expected record per checked cycle, compared mid-cycle.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (sbq.size() > 0) begin
        e = sbq.pop_front();
        chk(e.tag, e.dut, "stall", 32'(o_stall[e.dut]), 32'(e.stall));
        chk(e.tag, e.dut, "ex_bubble", 32'(o_bub[e.dut]), 32'(e.bub));
        chk(e.tag, e.dut, "of_squash", 32'(o_sq[e.dut]), 32'(e.sq));
        chk(e.tag, e.dut, "wb_expect", 32'(o_wbe[e.dut]), 32'(e.wbe));
        if (e.wbe) chk(e.tag, e.dut, "wb_rd_exp", 32'(o_wbrd[e.dut]), 32'(e.wbrd));
        if (e.cchk) begin
          chk(e.tag, e.dut, "stall_cnt", o_scnt[e.dut], 32'(e.scnt));
          chk(e.tag, e.dut, "flush_cnt", o_fcnt[e.dut], 32'(e.fcnt));
        end
      end
    end
  end

  initial begin
    int  ec;
    logic s;
    rst = 1'b1; br_taken = 1'b0;
    of_valid = 1'b1; of_rs1 = 5'd2; of_use1 = 1'b1; of_rs2 = 5'd3; of_use2 = 1'b1;
    of_rd = 5'd1; of_wb = 1'b1; of_isld = 1'b0;

    // reset held with a valid OF instruction
    repeat (3) cyc(alu(1, 2, 3), 1'b1, 1'b0, EC(0, 0, 0, 0, 0, 0, 0, 0));

    // add r3 ; add r4,r3,r5 (no forwarding)
    cyc(alu(3, 1, 2), 1'b0, 1'b0, E(0, 0, 0, 0, 0, 0));
    cyc(alu(4, 3, 5), 1'b0, 1'b0, E(0, 1, 1, 0, 0, 0));
    cyc(alu(4, 3, 5), 1'b0, 1'b0, E(0, 1, 1, 0, 0, 0));
    cyc(alu(4, 3, 5), 1'b0, 1'b0, E(0, 1, 1, 0, 1, 3));
    cyc(alu(4, 3, 5), 1'b0, 1'b0, EC(0, 0, 0, 0, 0, 0, 3, 0));
    cyc(nop_i(), 1'b0, 1'b0, E(0, 0, 1, 0, 0, 0));
    cyc(nop_i(), 1'b0, 1'b0, E(0, 0, 1, 0, 0, 0));
    cyc(nop_i(), 1'b0, 1'b0, E(0, 0, 1, 0, 1, 4));

    // forwarding build: load-use stalls once, alu-use not at all
    rst_cycle();
    cyc(ldi(3, 1), 1'b0, 1'b0, E(1, 0, 0, 0, 0, 0));
    cyc(alu(4, 3, 5), 1'b0, 1'b0, E(1, 1, 1, 0, 0, 0));
    cyc(alu(4, 3, 5), 1'b0, 1'b0, EC(1, 0, 0, 0, 0, 0, 1, 0));
    cyc(alu(3, 1, 2), 1'b0, 1'b0, E(1, 0, 0, 0, 1, 3));
    cyc(alu(4, 3, 5), 1'b0, 1'b0, E(1, 0, 0, 0, 0, 0));
    cyc(nop_i(), 1'b0, 1'b0, EC(1, 0, 1, 0, 1, 4, 1, 0));

    // call ; ret, then call ; independent ; ret
    rst_cycle();
    cyc(call_i(), 1'b0, 1'b0, E(0, 0, 0, 0, 0, 0));
    cyc(ret_i(), 1'b0, 1'b0, E(0, 1, 1, 0, 0, 0));
    cyc(ret_i(), 1'b0, 1'b0, E(0, 1, 1, 0, 0, 0));
    cyc(ret_i(), 1'b0, 1'b0, E(0, 1, 1, 0, 1, 31));
    cyc(ret_i(), 1'b0, 1'b0, EC(0, 0, 0, 0, 0, 0, 3, 0));
    cyc(call_i(), 1'b0, 1'b0, E(0, 0, 0, 0, 0, 0));
    cyc(alu(7, 1, 2), 1'b0, 1'b0, E(0, 0, 0, 0, 0, 0));
    cyc(ret_i(), 1'b0, 1'b0, E(0, 1, 1, 0, 0, 0));
    cyc(ret_i(), 1'b0, 1'b0, E(0, 1, 1, 0, 1, 31));
    cyc(ret_i(), 1'b0, 1'b0, EC(0, 0, 0, 0, 1, 7, 5, 0));

    // taken branch beats a hazard; branch over a clean instruction
    rst_cycle();
    cyc(alu(3, 1, 2), 1'b0, 1'b0, E(0, 0, 0, 0, 0, 0));
    cyc(alu(4, 3, 5), 1'b0, 1'b1, EC(0, 0, 1, 1, 0, 0, 0, 0));
    cyc(nop_i(), 1'b0, 1'b0, EC(0, 0, 1, 0, 0, 0, 0, 1));
    cyc(nop_i(), 1'b0, 1'b0, E(0, 0, 1, 0, 1, 3));
    cyc(nop_i(), 1'b0, 1'b0, E(0, 0, 1, 0, 0, 0));
    cyc(alu(8, 1, 2), 1'b0, 1'b1, E(0, 0, 1, 1, 0, 0));
    cyc(nop_i(), 1'b0, 1'b0, EC(0, 0, 1, 0, 0, 0, 0, 2));
    cyc(nop_i(), 1'b0, 1'b0, E(0, 0, 1, 0, 0, 0));
    cyc(nop_i(), 1'b0, 1'b0, E(0, 0, 1, 0, 0, 0));

    // rs1==rs2 counted once, rs2-only match, use gating, r0, invalid OF
    rst_cycle();
    cyc(alu(6, 1, 2), 1'b0, 1'b0, E(0, 0, 0, 0, 0, 0));
    cyc(alu(9, 6, 6), 1'b0, 1'b0, E(0, 1, 1, 0, 0, 0));
    cyc(alu(9, 6, 6), 1'b0, 1'b0, E(0, 1, 1, 0, 0, 0));
    cyc(alu(9, 6, 6), 1'b0, 1'b0, E(0, 1, 1, 0, 1, 6));
    cyc(alu(9, 6, 6), 1'b0, 1'b0, EC(0, 0, 0, 0, 0, 0, 3, 0));
    cyc(alu(10, 1, 9), 1'b0, 1'b0, E(0, 1, 1, 0, 0, 0));
    cyc(alu(10, 1, 9), 1'b0, 1'b0, E(0, 1, 1, 0, 0, 0));
    cyc(alu(10, 1, 9), 1'b0, 1'b0, E(0, 1, 1, 0, 1, 9));
    cyc(alu(10, 1, 9), 1'b0, 1'b0, EC(0, 0, 0, 0, 0, 0, 6, 0));
    cyc(raw(1'b1, 5'd10, 1'b0, 5'd1, 1'b1, 5'd11, 1'b1, 1'b0), 1'b0, 1'b0, E(0, 0, 0, 0, 0, 0));
    cyc(alu(0, 1, 2), 1'b0, 1'b0, E(0, 0, 0, 0, 0, 0));
    cyc(alu(12, 0, 0), 1'b0, 1'b0, E(0, 1, 1, 0, 1, 10));
    cyc(raw(1'b0, 5'd0, 1'b1, 5'd0, 1'b1, 5'd12, 1'b1, 1'b0), 1'b0, 1'b0, E(0, 0, 1, 0, 1, 11));

    // 4-bit counter saturation under a self-dependent chain, then reset mid-stall
    rst_cycle();
    ec = 0;
    for (int n = 1; n <= 30; n++) begin
      s = ((n - 1) % 4) != 0;
      cyc(alu(3, 3, 5), (n == 30), 1'b0, EC(2, s, s, 0, (n % 4) == 0, 3, ec, 0));
      if (s && ec < 15) ec++;
    end
    cyc(alu(3, 3, 5), 1'b0, 1'b0, EC(2, 0, 0, 0, 0, 0, 0, 0));
    cyc(alu(3, 3, 5), 1'b0, 1'b0, EC(2, 1, 1, 0, 0, 0, 0, 0));

    repeat (2) @(posedge clk);
    checks++;
    if (sbq.size() != 0) begin
      errors++;
      $display("FAIL drain: %0d records left, expected 0", sbq.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
